// File: rtl/top_memoryaccess.sv
// MemoryAccess stage: runs load/store on the req/ack data bus and registers *_mw results.
// Optional: define MEMACC_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module top_memoryaccess #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned OPLEN         = 9,
  parameter int unsigned ACK_TIMEOUT   = 16,
  parameter int unsigned USE_LOAD_BIT  = 3,
  parameter int unsigned USE_STORE_BIT = 4,
  parameter int unsigned FUNCT3_BIT_L  = 0,
  parameter int unsigned FUNCT3_BIT_M  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memoryaccess,
  input  logic             phase_writeback,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic             jump_state_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall_memoryaccess,
  output logic [XLEN-1:0]  rd_data_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic [4:0]       rdsel_mw,
  output logic             jump_state_mw,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic             bus_err_mw,
  output logic             misalign_mw
);

  localparam int unsigned CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       fn_q, fn_d;
  logic [XLEN-1:0]  ld_q, ld_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  rd_data_q, rd_data_d, next_pc_q, next_pc_d;
  logic [4:0]       rdsel_q, rdsel_d;
  logic             jump_q, jump_d, bus_err_q, bus_err_d, mis_q, mis_d;
  logic [OPLEN-1:0] op_q, op_d;

  logic             is_load, is_store, memop, misalign, stall;
  logic [2:0]       funct3;
  logic [1:0]       off;
  logic             size_byte, size_half;
  logic [3:0]       be_st;
  logic [XLEN-1:0]  wdata_st, ld_val;
  logic [7:0]       lane8;
  logic [15:0]      lane16;

  assign funct3    = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
  assign is_load   = decoded_op_em[USE_LOAD_BIT];
  assign is_store  = decoded_op_em[USE_STORE_BIT];
  assign memop     = is_load | is_store;
  assign off       = alu_out_em[1:0];
  assign size_byte = (funct3[1:0] == 2'b00);
  assign size_half = (funct3[1:0] == 2'b01);

`ifdef MEMACC_MISALIGN_TRAP_EN
  assign misalign = memop & ((size_half & off[0]) | (!size_byte & !size_half & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign stall = phase_memoryaccess & memop & ~misalign & (state_q != S_DONE);
  assign stall_memoryaccess = stall;

  // Store lanes; a misaligned half/word simply drops the low address bits here.
  always_comb begin
    be_st    = 4'b1111;
    wdata_st = rs2data_em;
    if (size_byte) begin
      be_st    = 4'b0001 << off;
      wdata_st = {4{rs2data_em[7:0]}};
    end else if (size_half) begin
      be_st    = 4'b0011 << {off[1], 1'b0};
      wdata_st = {2{rs2data_em[15:0]}};
    end
  end

  always_comb begin
    lane8  = dmem_rdata[{off_q, 3'b000} +: 8];
    lane16 = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    case (fn_q[1:0])
      2'b00:   ld_val = fn_q[2] ? {{(XLEN-8){1'b0}}, lane8}
                                : {{(XLEN-8){lane8[7]}}, lane8};
      2'b01:   ld_val = fn_q[2] ? {{(XLEN-16){1'b0}}, lane16}
                                : {{(XLEN-16){lane16[15]}}, lane16};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    off_d     = off_q;
    fn_d      = fn_q;
    ld_d      = ld_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    next_pc_d = next_pc_q;
    rdsel_d   = rdsel_q;
    jump_d    = jump_q;
    op_d      = op_q;
    bus_err_d = bus_err_q;
    mis_d     = mis_q;

    case (state_q)
      S_IDLE: begin
        if (phase_memoryaccess && memop && !misalign) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_out_em[XLEN-1:2], 2'b00};
          wdata_d = wdata_st;
          be_d    = is_store ? be_st : 4'b1111;
          off_d   = off;
          fn_d    = funct3;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          ld_d    = ld_val;
          state_d = S_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (phase_writeback) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Memops only reach here in DONE (or when trapped), so err_q/ld_q belong to this op.
    if (phase_memoryaccess && !stall) begin
      next_pc_d = next_pc_em;
      rdsel_d   = rdsel_em;
      jump_d    = jump_state_em;
      op_d      = decoded_op_em;
      mis_d     = misalign;
      bus_err_d = memop & ~misalign & err_q;
      if (misalign || !memop)  rd_data_d = alu_out_em;
      else if (err_q)          rd_data_d = '0;
      else if (is_load)        rd_data_d = ld_q;
      else                     rd_data_d = alu_out_em;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      off_q     <= '0;
      fn_q      <= '0;
      ld_q      <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      next_pc_q <= '0;
      rdsel_q   <= '0;
      jump_q    <= 1'b0;
      op_q      <= '0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      off_q     <= off_d;
      fn_q      <= fn_d;
      ld_q      <= ld_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      next_pc_q <= next_pc_d;
      rdsel_q   <= rdsel_d;
      jump_q    <= jump_d;
      op_q      <= op_d;
      bus_err_q <= bus_err_d;
      mis_q     <= mis_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign rd_data_mw    = rd_data_q;
  assign next_pc_mw    = next_pc_q;
  assign rdsel_mw      = rdsel_q;
  assign jump_state_mw = jump_q;
  assign decoded_op_mw = op_q;
  assign bus_err_mw    = bus_err_q;
`ifdef MEMACC_MISALIGN_TRAP_EN
  assign misalign_mw   = mis_q;
`else
  assign misalign_mw   = 1'b0;
`endif

endmodule
